// File: rtl/pipe_field_scroller.sv
// pipe_field_scroller: full ROWS x COLS pipe field for the LED-matrix game.
// Generates pipe columns internally, scrolls them toward the far edge and
// reports bird collision, pipe-pass pulses and a saturating score.
// Optional build macro: PIPE_FIELD_NARROW_EN (gap shrinks as score grows).
module pipe_field_scroller #(
  parameter int          ROWS      = 8,
  parameter int          COLS      = 8,
  parameter int          GAP_H     = 3,
  parameter int          SPACING   = 4,
  parameter int          BIRD_COL  = 2,
  parameter int          SCORE_W   = 8,
  parameter logic [7:0]  LFSR_SEED = 8'h01
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cycle,
  input  logic                      lose,
  input  logic [$clog2(ROWS):0]     bird_row,
  output logic [ROWS*COLS-1:0]      field,
  output logic                      pass_pulse,
  output logic [SCORE_W-1:0]        score,
  output logic                      collision
);

  localparam int BR_W = $clog2(ROWS) + 1;
  localparam int SP_W = $clog2(SPACING);

  logic [SP_W-1:0]      spacing_cnt;
  logic [7:0]           lfsr;
  logic [7:0]           lfsr_next;
  logic [ROWS-1:0]      pipe_col;
  logic [ROWS-1:0]      new_col;
  logic [ROWS*COLS-1:0] shifted;
  logic                 bird_col_busy;
  int unsigned          eff_h;
  int unsigned          gap_base;

  // Fibonacci LFSR step, x^8+x^6+x^5+x^4+1
  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

`ifdef PIPE_FIELD_NARROW_EN
  // Effective gap height shrinks by one row per 8 points, never below 2
  always_comb begin
    int unsigned shrink;
    shrink = 32'(score >> 3);
    if (GAP_H < 2)
      eff_h = GAP_H;
    else if (shrink >= 32'(GAP_H - 2))
      eff_h = 2;
    else
      eff_h = 32'(GAP_H) - shrink;
  end
`else
  // Fixed gap height
  always_comb begin
    eff_h = GAP_H;
  end
`endif

  // Pipe column pattern: gap rows clear, all other rows set
  always_comb begin
    gap_base = 32'(lfsr) % (32'(ROWS) - eff_h + 1);
    pipe_col = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      pipe_col[r] = !((r >= gap_base) && (r < gap_base + eff_h));
    new_col = (spacing_cnt == '0) ? pipe_col : '0;
  end

  // Field shifted one column away from the entry edge, new column at 0
  always_comb begin
    shifted = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      shifted[r*COLS] = new_col[r];
      for (int unsigned c = 1; c < COLS; c++)
        shifted[r*COLS+c] = field[r*COLS+c-1];
    end
  end

  // Any pipe pixel currently in the bird column
  always_comb begin
    bird_col_busy = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++)
      bird_col_busy = bird_col_busy | field[r*COLS+BIRD_COL];
  end

  // Bird hits a pipe pixel or leaves the field
  always_comb begin
    collision = (bird_row >= BR_W'(ROWS));
    for (int unsigned r = 0; r < ROWS; r++)
      if (bird_row == BR_W'(r))
        collision = field[r*COLS+BIRD_COL];
  end

  // Field, spacing, LFSR, score and pass pulse state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      field       <= '0;
      spacing_cnt <= '0;
      lfsr        <= LFSR_SEED;
      score       <= '0;
      pass_pulse  <= 1'b0;
    end else if (lose) begin
      pass_pulse <= 1'b0;
    end else if (cycle) begin
      field       <= shifted;
      spacing_cnt <= (spacing_cnt == SP_W'(SPACING - 1)) ? '0 : spacing_cnt + 1'b1;
      if (spacing_cnt == '0)
        lfsr <= lfsr_next;
      pass_pulse <= bird_col_busy;
      if (bird_col_busy && (score != '1))
        score <= score + 1'b1;
    end else begin
      pass_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_field_scroller.sv
// Scoreboard bench for pipe_field_scroller: stimulus pushes hand-computed
// expectations tagged with a cycle number; a monitor compares on negedge.
module tb_pipe_field_scroller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cycle;
  logic        lose;
  logic [3:0]  bird_row;
  logic [63:0] field;
  logic        pass_pulse;
  logic [7:0]  score;
  logic        collision;
  logic [63:0] field2;
  logic        pass2;
  logic [1:0]  score2;
  logic        coll2;

  int unsigned cyc_cnt = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {
    int unsigned cyc;
    string       nm;
    logic [63:0] f;
    logic        p;
    logic [7:0]  s;
    logic        c;
    logic [1:0]  s2;
  } exp_t;

  exp_t q[$];

  pipe_field_scroller dut (
    .clk(clk), .reset(reset), .cycle(cycle), .lose(lose), .bird_row(bird_row),
    .field(field), .pass_pulse(pass_pulse), .score(score), .collision(collision)
  );

  pipe_field_scroller #(.SCORE_W(2)) dut_s2 (
    .clk(clk), .reset(reset), .cycle(cycle), .lose(lose), .bird_row(bird_row),
    .field(field2), .pass_pulse(pass2), .score(score2), .collision(coll2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [63:0] pc(input logic [7:0] p, input int c);
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < 8; r++) f[r*8+c] = p[r];
    return f;
  endfunction

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string nm, input logic [63:0] f, input logic p,
                    input logic [7:0] s, input logic c, input logic [1:0] s2);
    exp_t e;
    e.cyc = cyc_cnt; e.nm = nm; e.f = f; e.p = p; e.s = s; e.c = c; e.s2 = s2;
    q.push_back(e);
  endtask

  task automatic pulse();
    cycle = 1'b1;
    tk();
    cycle = 1'b0;
  endtask

  // Monitor: compare every expectation due in the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == cyc_cnt) begin
        e = q.pop_front();
        total++;
        if (field !== e.f) begin
          bad++;
          $display("FAIL %s field: got %h want %h", e.nm, field, e.f);
        end
        total++;
        if (pass_pulse !== e.p) begin
          bad++;
          $display("FAIL %s pass_pulse: got %b want %b", e.nm, pass_pulse, e.p);
        end
        total++;
        if (score !== e.s) begin
          bad++;
          $display("FAIL %s score: got %0d want %0d", e.nm, score, e.s);
        end
        total++;
        if (collision !== e.c) begin
          bad++;
          $display("FAIL %s collision: got %b want %b", e.nm, collision, e.c);
        end
        total++;
        if (score2 !== e.s2) begin
          bad++;
          $display("FAIL %s score_w2: got %0d want %0d", e.nm, score2, e.s2);
        end
      end
    end
  end

  localparam logic [7:0] PA = 8'hF1;  // gap_base 1
  localparam logic [7:0] PB = 8'hE3;  // gap_base 2
  localparam logic [7:0] PC = 8'h8F;  // gap_base 4
  localparam logic [7:0] PE = 8'h1F;  // gap_base 5

  initial begin
    reset = 1'b0; cycle = 1'b0; lose = 1'b0; bird_row = 4'd0;
    tk();
    ex("reset", '0, 0, 0, 0, 0);
    tk();
    reset = 1'b1;
    tk();
    ex("idle", '0, 0, 0, 0, 0);

    pulse(); ex("p1", pc(PA,0), 0, 0, 0, 0);
    pulse(); ex("p2", pc(PA,1), 0, 0, 0, 0);
    pulse(); ex("p3_bird0", pc(PA,2), 0, 0, 1, 0);
    tk(); bird_row = 4'd2; ex("p3_bird2", pc(PA,2), 0, 0, 0, 0);
    tk(); bird_row = 4'd8; ex("p3_bird8", pc(PA,2), 0, 0, 1, 0);
    tk(); bird_row = 4'd15; ex("p3_bird15", pc(PA,2), 0, 0, 1, 0);
    tk(); bird_row = 4'd0;

    pulse(); ex("p4_pass", pc(PA,3), 1, 1, 0, 1);
    tk();    ex("p4_pulse_end", pc(PA,3), 0, 1, 0, 1);
    pulse(); ex("p5_nopipe", pc(PB,0) | pc(PA,4), 0, 1, 0, 1);
    pulse(); ex("p6", pc(PB,1) | pc(PA,5), 0, 1, 0, 1);
    pulse(); ex("p7", pc(PB,2) | pc(PA,6), 0, 1, 1, 1);

    for (int i = 0; i < 10; i++) begin
      lose = 1'b1;
      cycle = (i % 2 == 0);
      tk();
      ex("lose", pc(PB,2) | pc(PA,6), 0, 1, 1, 1);
    end
    lose = 1'b0; cycle = 1'b0;

    pulse(); ex("p8_pass", pc(PB,3) | pc(PA,7), 1, 2, 0, 2);
    pulse(); ex("p9_drop", pc(PC,0) | pc(PB,4), 0, 2, 0, 2);

    cycle = 1'b1;
    for (int k = 10; k <= 20; k++) begin
      tk();
      if (k == 12) ex("p12", pc(PC,3) | pc(PB,7), 1, 3, 0, 3);
      if (k == 16) ex("p16_sat", pc(PB,3) | pc(PC,7), 1, 4, 0, 3);
      if (k == 20) begin
        cycle = 1'b0;
        ex("p20", pc(PE,3) | pc(PB,7), 1, 5, 0, 3);
      end
    end

    tk();
    reset = 1'b0;
    ex("async_reset", '0, 0, 0, 0, 0);
    tk();
    ex("reset_hold", '0, 0, 0, 0, 0);
    reset = 1'b1;
    tk();
    pulse(); ex("re_p1", pc(PA,0), 0, 0, 0, 0);

    for (int w = 0; w < 20 && q.size() > 0; w++) tk();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_field_scroller.md
Name: pipe_field_scroller

Overview:
- Parametrised successor to the single-row pipe shifter. Holds the full ROWS x COLS pipe field of the LED matrix.
- Generates new pipe columns internally: spacing counter, plus an LFSR that picks the gap position.
- Scrolls the field one column per cycle pulse.
- Reports bird collision, pipe-pass pulses and a saturating score to the game FSM and display driver.

Parameters:
- ROWS, 8, matrix rows (>= GAP_H+1)
- COLS, 8, matrix columns
- GAP_H, 3, gap height in rows (>= 1)
- SPACING, 4, columns between pipe starts, including the pipe column (>= 2)
- BIRD_COL, 2, column index the bird occupies (< COLS-1)
- SCORE_W, 8, score counter width
- LFSR_SEED, 8'h01, nonzero reset value of 8-bit LFSR

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cycle  in  1  scroll-enable strobe; one shift per clk edge where sampled high
- lose  in  1  freeze: hold all state while high
- bird_row  in  $clog2(ROWS)+1  bird vertical position
- field  out  ROWS*COLS  pipe bitmap; bit r*COLS+c = row r, column c; column 0 = entry edge
- pass_pulse  out  1  one-clk pulse when a pipe column leaves BIRD_COL
- score  out  SCORE_W  pipes passed, saturating
- collision  out  1  bird overlaps pipe or is out of field

Behaviour:
- Reset (reset==0, async):
  - field=0, spacing_cnt=0, lfsr=LFSR_SEED, score=0, pass_pulse=0.
  - Deassertion is sampled synchronously by the design as usual.
- Priority per posedge: reset > lose > cycle > hold.
- lose==1:
  - field, spacing_cnt, lfsr and score hold.
  - pass_pulse=0.
  - cycle is ignored.
- cycle==1 and lose==0 (shift):
  - field[r][c] <= field[r][c-1] for c=1..COLS-1; column COLS-1 contents are discarded.
  - Column 0 <= new_col.
  - If spacing_cnt==0, new_col is a pipe column: rows gap_base..gap_base+GAP_H-1 = 0, all other rows = 1, with gap_base = lfsr mod (ROWS-GAP_H+1). The lfsr advances one step.
  - Otherwise new_col = 0 and the lfsr holds.
  - spacing_cnt <= (spacing_cnt==SPACING-1) ? 0 : spacing_cnt+1.
- LFSR:
  - Fibonacci, shift left, bit0 <= lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] (x^8+x^6+x^5+x^4+1).
  - Never zero. Sequence from 8'h01 is 01, 02, 04, 08, 11, ...
- pass_pulse:
  - Registered. High for exactly the clk following a shift edge at which the pre-shift column BIRD_COL was nonzero. Otherwise 0.
- score:
  - Increments on the same edge pass_pulse is set.
  - Saturates at 2^SCORE_W-1; no wrap.
- collision:
  - Combinational from the registered field: 1 if bird_row >= ROWS, else field[bird_row][BIRD_COL].
  - Valid during lose; value holds with the field.
- cycle held high continuously: shift every clk; no edge detection on cycle.

Optional Feature:
- Macro PIPE_FIELD_NARROW_EN.
- Defined: the effective gap height is GAP_H - floor(score/8), floored at 2 (if GAP_H < 2, GAP_H is used unchanged).
  - The effective height is sampled when a pipe column is generated.
  - gap_base modulus uses the effective height.
- Undefined: gap height is always GAP_H; no extra logic.

Test Plan:
- Defaults. Reset low, then release; one cycle pulse -> column 0 = rows {0,4,5,6,7} set (gap_base=1), i.e. field bits 0,32,40,48,56 = 1, all others 0. spacing_cnt=1, lfsr=02.
- Three more cycle pulses -> pipe at column 3. Fifth pulse inserts a pipe with gap_base=2 (rows {0,1,5,6,7} set) at column 0.
- Pass: on the 4th pulse the pipe leaves column 2 -> pass_pulse high for one clk, score=1. The 8th pulse gives score=2. A pipe shifted out of column 7 disappears.
- Collision after 3 pulses (pipe at column 2, gap rows 1..3):
  - bird_row=0 -> collision=1; bird_row=2 -> 0; bird_row=8 -> 1.
  - With no pipe at column 2 and bird_row=0 -> 0.
- Lose: raise lose with cycle toggling for 10 clks -> field, score and collision unchanged, pass_pulse 0. Drop lose -> shifting resumes from the frozen state.
- Reset mid-run at score=5 with a nonzero field -> all outputs 0 immediately (async). After release the first pipe repeats the gap_base=1 pattern. Separately, SCORE_W=2 with 4 passes -> score stays 3.
